vx_fetch_warp_sched: RTL and testbench

- Per-core warp scheduler that sequences the fetch stage: selects one eligible warp per cycle and presents {wid, PC, tmask, uuid} on the schedule handshake consumed by the fetch unit.
- Enforces one outstanding fetch per warp. An issued warp stays stalled until the decode/execute side returns an unlock carrying its next PC and tmask.
- Handles warp spawn and termination. Sits between the warp-control/branch logic and the fetch unit.

---
 rtl/vx_fetch_warp_sched_if.sv | 24 ++
 rtl/vx_fetch_warp_sched.sv | 141 ++++++++++++++
 tb/tb_vx_fetch_warp_sched.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_fetch_warp_sched_if.sv
// Schedule handshake between the warp scheduler (master) and the fetch unit (slave).
interface vx_fetch_warp_sched_if #(
  parameter int unsigned NW_W        = 2,
  parameter int unsigned PC_BITS     = 31,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned UUID_WIDTH  = 44
);
  logic                   sched_valid;
  logic [NW_W-1:0]        sched_wid;
  logic [PC_BITS-1:0]     sched_pc;
  logic [NUM_THREADS-1:0] sched_tmask;
  logic [UUID_WIDTH-1:0]  sched_uuid;
  logic                   sched_ready;

  modport master (
    output sched_valid, sched_wid, sched_pc, sched_tmask, sched_uuid,
    input  sched_ready
  );

  modport slave (
    input  sched_valid, sched_wid, sched_pc, sched_tmask, sched_uuid,
    output sched_ready
  );
endinterface

// File: rtl/vx_fetch_warp_sched.sv
// Round-robin fetch warp scheduler: one outstanding fetch per warp, spawn/unlock/terminate handling.
module vx_fetch_warp_sched #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned PC_BITS     = 31,
  parameter int unsigned UUID_WIDTH  = 44,
  parameter logic [PC_BITS-1:0] START_PC = 31'h40000000,
  localparam int unsigned NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   spawn_valid,
  input  logic [NW_W-1:0]        spawn_wid,
  input  logic [PC_BITS-1:0]     spawn_pc,
  input  logic [NUM_THREADS-1:0] spawn_tmask,
  input  logic                   unlock_valid,
  input  logic [NW_W-1:0]        unlock_wid,
  input  logic [PC_BITS-1:0]     unlock_pc,
  input  logic [NUM_THREADS-1:0] unlock_tmask,
  vx_fetch_warp_sched_if.master  sched_if,
  output logic [NUM_WARPS-1:0]   active_warps,
  output logic [NUM_WARPS-1:0]   stalled_warps,
  output logic                   busy
);

  logic [NUM_WARPS-1:0]   active_q, active_d;
  logic [NUM_WARPS-1:0]   stalled_q, stalled_d;
  logic [PC_BITS-1:0]     pc_q    [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
  logic [UUID_WIDTH-1:0]  uuid_q;
  logic [NW_W-1:0]        rr_q;
  logic                   busy_q;

  logic                   sched_valid_q;
  logic [NW_W-1:0]        sched_wid_q;
  logic [PC_BITS-1:0]     sched_pc_q;
  logic [NUM_THREADS-1:0] sched_tmask_q;
  logic [UUID_WIDTH-1:0]  sched_uuid_q;

  logic [NUM_WARPS-1:0]   eligible;
  logic                   win_valid;
  logic [NW_W-1:0]        win_wid;
  logic                   slot_free;
  logic                   load;
  logic                   spawn_en;
  logic                   unlock_en;

  // First eligible warp at or after ptr, wrapping modulo NUM_WARPS.
  function automatic logic [NW_W:0] rr_pick(input logic [NUM_WARPS-1:0] elig,
                                            input logic [NW_W-1:0] ptr);
    logic            found;
    logic [NW_W-1:0] w;
    int unsigned     idx;
    found = 1'b0;
    w     = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
      if (!found && elig[NW_W'(idx)]) begin
        found = 1'b1;
        w     = NW_W'(idx);
      end
    end
    return {found, w};
  endfunction

  // Next-state for the per-warp flags; arbitration sees registered state only.
  always_comb begin
    eligible             = active_q & ~stalled_q;
    {win_valid, win_wid} = rr_pick(eligible, rr_q);
    slot_free            = ~sched_valid_q | sched_if.sched_ready;
    load                 = slot_free & win_valid;
    spawn_en             = spawn_valid & ~active_q[spawn_wid] & (spawn_tmask != '0);
    unlock_en            = unlock_valid & stalled_q[unlock_wid];
    active_d             = active_q;
    stalled_d            = stalled_q;
    if (spawn_en) begin
      active_d[spawn_wid]  = 1'b1;
      stalled_d[spawn_wid] = 1'b0;
    end
    // Unlock is applied after spawn so it wins on a shared wid.
    if (unlock_en) begin
      stalled_d[unlock_wid] = 1'b0;
      if (unlock_tmask == '0) active_d[unlock_wid] = 1'b0;
    end
    if (load) stalled_d[win_wid] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active_q      <= NUM_WARPS'(1);
      stalled_q     <= '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
        pc_q[i]    <= (i == 0) ? START_PC : '0;
        tmask_q[i] <= (i == 0) ? NUM_THREADS'(1) : '0;
      end
      uuid_q        <= '0;
      rr_q          <= '0;
      busy_q        <= 1'b1;
      sched_valid_q <= 1'b0;
      sched_wid_q   <= '0;
      sched_pc_q    <= '0;
      sched_tmask_q <= '0;
      sched_uuid_q  <= '0;
    end else begin
      active_q  <= active_d;
      stalled_q <= stalled_d;
      busy_q    <= |active_d;
      if (spawn_en) begin
        pc_q[spawn_wid]    <= spawn_pc;
        tmask_q[spawn_wid] <= spawn_tmask;
      end
      if (unlock_en) begin
        pc_q[unlock_wid]    <= unlock_pc;
        tmask_q[unlock_wid] <= unlock_tmask;
      end
      // Output slot: reload when free, otherwise hold.
      if (slot_free) begin
        sched_valid_q <= win_valid;
        if (win_valid) begin
          sched_wid_q   <= win_wid;
          sched_pc_q    <= pc_q[win_wid];
          sched_tmask_q <= tmask_q[win_wid];
          sched_uuid_q  <= uuid_q;
          uuid_q        <= uuid_q + 1'b1;
          rr_q          <= (win_wid == NW_W'(NUM_WARPS - 1)) ? '0 : win_wid + 1'b1;
        end
      end
    end
  end

  assign sched_if.sched_valid = sched_valid_q;
  assign sched_if.sched_wid   = sched_wid_q;
  assign sched_if.sched_pc    = sched_pc_q;
  assign sched_if.sched_tmask = sched_tmask_q;
  assign sched_if.sched_uuid  = sched_uuid_q;
  assign active_warps         = active_q;
  assign stalled_warps        = stalled_q;
  assign busy                 = busy_q;

endmodule

// File: tb/tb_vx_fetch_warp_sched.sv
// Randomized + directed bench for vx_fetch_warp_sched against an array-based reference model.
module tb_vx_fetch_warp_sched;
  localparam int NW = 4;
  localparam logic [30:0] START = 31'h40000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        spawn_valid;
  logic [1:0]  spawn_wid;
  logic [30:0] spawn_pc;
  logic [3:0]  spawn_tmask;
  logic        unlock_valid;
  logic [1:0]  unlock_wid;
  logic [30:0] unlock_pc;
  logic [3:0]  unlock_tmask;
  logic [3:0]  active_warps, stalled_warps;
  logic        busy;

  vx_fetch_warp_sched_if sif();

  vx_fetch_warp_sched dut (
    .clk(clk), .reset_n(reset_n),
    .spawn_valid(spawn_valid), .spawn_wid(spawn_wid), .spawn_pc(spawn_pc), .spawn_tmask(spawn_tmask),
    .unlock_valid(unlock_valid), .unlock_wid(unlock_wid), .unlock_pc(unlock_pc), .unlock_tmask(unlock_tmask),
    .sched_if(sif), .active_warps(active_warps), .stalled_warps(stalled_warps), .busy(busy)
  );

  // Narrow-uuid instance to exercise counter wrap in a few cycles.
  logic       b_reset_n, b_unlock_valid, b_busy;
  logic [3:0] b_active, b_stalled;
  vx_fetch_warp_sched_if #(.UUID_WIDTH(4)) sif_b();

  vx_fetch_warp_sched #(.UUID_WIDTH(4)) dut_b (
    .clk(clk), .reset_n(b_reset_n),
    .spawn_valid(1'b0), .spawn_wid(2'd0), .spawn_pc(31'd0), .spawn_tmask(4'd0),
    .unlock_valid(b_unlock_valid), .unlock_wid(2'd0), .unlock_pc(START), .unlock_tmask(4'd1),
    .sched_if(sif_b), .active_warps(b_active), .stalled_warps(b_stalled), .busy(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          m_act [NW];
  bit          m_stl [NW];
  logic [30:0] m_pc  [NW];
  logic [3:0]  m_tm  [NW];
  logic [43:0] m_uuid;
  int          m_rr;
  bit          m_sv;
  int          m_wid;
  logic [30:0] m_spc;
  logic [3:0]  m_stm;
  logic [43:0] m_suuid;

  task automatic model_edge();
    int  win;
    bit  free, do_spawn, do_unlock;
    if (!reset_n) begin
      for (int i = 0; i < NW; i++) begin
        m_act[i] = (i == 0);
        m_stl[i] = 1'b0;
        m_pc[i]  = (i == 0) ? START : 31'd0;
        m_tm[i]  = (i == 0) ? 4'd1 : 4'd0;
      end
      m_uuid = '0; m_rr = 0; m_sv = 1'b0; m_wid = 0; m_spc = '0; m_stm = '0; m_suuid = '0;
      return;
    end
    win = -1;
    for (int k = 0; k < NW; k++) begin
      int w;
      w = (m_rr + k) % NW;
      if (win < 0 && m_act[w] && !m_stl[w]) win = w;
    end
    free      = !m_sv || sif.sched_ready;
    do_spawn  = spawn_valid && !m_act[spawn_wid] && (spawn_tmask != 4'd0);
    do_unlock = unlock_valid && m_stl[unlock_wid];
    if (free && win >= 0) begin
      m_sv = 1'b1; m_wid = win; m_spc = m_pc[win]; m_stm = m_tm[win]; m_suuid = m_uuid;
      m_stl[win] = 1'b1;
      m_uuid = m_uuid + 44'd1;
      m_rr = (win + 1) % NW;
    end else if (free) begin
      m_sv = 1'b0;
    end
    if (do_spawn) begin
      m_act[spawn_wid] = 1'b1; m_stl[spawn_wid] = 1'b0;
      m_pc[spawn_wid] = spawn_pc; m_tm[spawn_wid] = spawn_tmask;
    end
    if (do_unlock) begin
      m_stl[unlock_wid] = 1'b0;
      m_pc[unlock_wid] = unlock_pc; m_tm[unlock_wid] = unlock_tmask;
      if (unlock_tmask == 4'd0) m_act[unlock_wid] = 1'b0;
    end
  endtask

  task automatic compare();
    logic [3:0] ea, es;
    for (int i = 0; i < NW; i++) begin
      ea[i] = m_act[i];
      es[i] = m_stl[i];
    end
    check("sched_valid", sif.sched_valid, m_sv);
    if (m_sv) begin
      check("sched_wid", sif.sched_wid, m_wid);
      check("sched_pc", sif.sched_pc, m_spc);
      check("sched_tmask", sif.sched_tmask, m_stm);
      check("sched_uuid", sif.sched_uuid, m_suuid);
    end
    check("active", active_warps, ea);
    check("stalled", stalled_warps, es);
    check("busy", busy, |ea);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic clear_in();
    spawn_valid = 1'b0; unlock_valid = 1'b0;
  endtask

  task automatic spawn(input int w, input logic [30:0] pc, input logic [3:0] tm);
    spawn_valid = 1'b1; spawn_wid = 2'(w); spawn_pc = pc; spawn_tmask = tm;
  endtask

  task automatic unlock(input int w, input logic [30:0] pc, input logic [3:0] tm);
    unlock_valid = 1'b1; unlock_wid = 2'(w); unlock_pc = pc; unlock_tmask = tm;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issues;
    reset_n = 1'b0; sif.sched_ready = 1'b1;
    spawn_valid = 1'b0; spawn_wid = '0; spawn_pc = '0; spawn_tmask = '0;
    unlock_valid = 1'b0; unlock_wid = '0; unlock_pc = '0; unlock_tmask = '0;
    b_reset_n = 1'b0; b_unlock_valid = 1'b0; sif_b.sched_ready = 1'b1;

    // Reset values
    step(); step();
    check("rst_valid", sif.sched_valid, 0);
    check("rst_active", active_warps, 4'b0001);
    check("rst_stalled", stalled_warps, 0);
    check("rst_busy", busy, 1);
    check("rst_fields", {sif.sched_wid, sif.sched_pc, sif.sched_tmask}, 0);
    check("rst_uuid", sif.sched_uuid, 0);

    // First issue after reset release
    reset_n = 1'b1;
    step();
    check("c1_valid", sif.sched_valid, 1);
    check("c1_wid", sif.sched_wid, 0);
    check("c1_pc", sif.sched_pc, START);
    check("c1_tmask", sif.sched_tmask, 4'b0001);
    check("c1_uuid", sif.sched_uuid, 0);
    step();
    check("c2_valid", sif.sched_valid, 0);
    check("c2_stalled", stalled_warps, 4'b0001);

    // Spawn 1..3, unlock 0: RR order 1,2,3,0
    spawn(1, 31'h100, 4'hF); unlock(0, 31'h10, 4'h1); step(); clear_in();
    spawn(2, 31'h200, 4'hF); step(); clear_in();
    check("rr1_wid", sif.sched_wid, 1); check("rr1_uuid", sif.sched_uuid, 1);
    spawn(3, 31'h300, 4'hF); step(); clear_in();
    check("rr2_wid", sif.sched_wid, 2); check("rr2_uuid", sif.sched_uuid, 2);
    step();
    check("rr3_wid", sif.sched_wid, 3); check("rr3_uuid", sif.sched_uuid, 3);
    step();
    check("rr0_wid", sif.sched_wid, 0); check("rr0_uuid", sif.sched_uuid, 4);
    check("rr0_pc", sif.sched_pc, 31'h10);
    check("rr_all_stalled", stalled_warps, 4'hF);

    // Back-pressure hold
    unlock(2, 31'h200, 4'hF); step(); clear_in();
    sif.sched_ready = 1'b0;
    unlock(3, 31'h300, 4'hF); step(); clear_in();
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", sif.sched_valid, 1);
      check("hold_wid", sif.sched_wid, 2);
      check("hold_pc", sif.sched_pc, 31'h200);
      check("hold_uuid", sif.sched_uuid, 5);
    end
    sif.sched_ready = 1'b1;
    step();
    check("after_hold_wid", sif.sched_wid, 3);

    // Terminate warp 1
    unlock(1, 31'h0, 4'h0); step(); clear_in();
    check("term_w1", active_warps[1], 0);

    // Ignored spawn to active warp and unlock to non-stalled warp
    sif.sched_ready = 1'b0;
    unlock(2, 31'h220, 4'hF); step(); clear_in();
    unlock(0, 31'h50, 4'h3); step(); clear_in();
    spawn(0, 31'h999, 4'hF); unlock(0, 31'h777, 4'h0); step(); clear_in();
    check("ign_active0", active_warps[0], 1);
    sif.sched_ready = 1'b1;
    step();
    check("ign_wid", sif.sched_wid, 0);
    check("ign_pc", sif.sched_pc, 31'h50);
    check("ign_tmask", sif.sched_tmask, 4'h3);

    // Reset while a request is pending
    sif.sched_ready = 1'b0; step();
    reset_n = 1'b0; step();
    check("mid_rst_valid", sif.sched_valid, 0);
    check("mid_rst_active", active_warps, 4'b0001);
    check("mid_rst_stalled", stalled_warps, 0);
    check("mid_rst_fields", {sif.sched_wid, sif.sched_pc, sif.sched_uuid}, 0);
    reset_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      sif.sched_ready = ($urandom_range(0, 3) != 0);
      reset_n = ($urandom_range(0, 299) != 0);
      clear_in();
      if ($urandom_range(0, 3) == 0)
        spawn(int'($urandom_range(0, 3)), 31'($urandom), 4'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        int w;
        w = int'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0)
          for (int k = 0; k < NW; k++) if (m_stl[k]) w = k;
        unlock(w, 31'($urandom), ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom));
      end
      step();
    end

    // Drain: terminate every warp
    reset_n = 1'b1; sif.sched_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      clear_in();
      for (int k = 0; k < NW; k++) if (m_stl[k]) unlock(k, 31'd0, 4'd0);
      step();
    end
    clear_in();
    check("drain_busy", busy, 0);
    check("drain_active", active_warps, 0);

    // uuid wrap on the narrow instance
    @(posedge clk); #1;
    b_reset_n = 1'b1;
    issues = 0;
    for (int c = 0; c < 120 && issues < 20; c++) begin
      b_unlock_valid = sif_b.sched_valid;
      @(posedge clk); #1;
      if (sif_b.sched_valid) begin
        check("wrap_uuid", sif_b.sched_uuid, issues % 16);
        check("wrap_fields", {sif_b.sched_wid, sif_b.sched_pc, sif_b.sched_tmask}, {2'd0, START, 4'd1});
        issues++;
      end
    end
    check("wrap_count", issues, 20);
    check("wrap_flags", {b_busy, b_active}, {1'b1, 4'b0001});
    check("wrap_stalled", b_stalled[3:1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
